// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity-type
// constants and the data-length clamp.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK_WAIT
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int BCNT_W = 4;

   function automatic logic [3:0] clamp_len(input logic [3:0] len, input int dw_max);
      if (len < 4'd5) return 4'd5;
      if (int'(len) > dw_max) return 4'(dw_max);
      return len;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing engine: edge counter (0..P-1), bit counter and 3-point majority
// vote around mid-bit; strobes bit_done_o at edge P-1.
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRE_W = 6
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              rx_i,
   input  logic              run_i,
   input  logic              start_i,
   input  logic [PRE_W-1:0]  prescale_i,
   output logic              bit_o,
   output logic              bit_done_o,
   output logic [BCNT_W-1:0] bit_cnt_o
);

   logic [PRE_W-1:0]  ecnt_q, ecnt_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic              s0_q, s0_d, s1_q, s1_d, maj_q, maj_d;
   logic [PRE_W-1:0]  half;
   logic              at_s0, at_s1, at_s2, at_last, maj_now;

   assign half    = prescale_i >> 1;
   assign at_s0   = run_i && (ecnt_q == half - PRE_W'(1));
   assign at_s1   = run_i && (ecnt_q == half);
   assign at_s2   = run_i && (ecnt_q == half + PRE_W'(1));
   assign at_last = run_i && (ecnt_q == prescale_i - PRE_W'(1));
   assign maj_now = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);

   // For P=4 the third sample and the decision share a cycle, so the vote
   // is taken combinationally there and held in maj_q otherwise.
   assign bit_o      = at_s2 ? maj_now : maj_q;
   assign bit_done_o = at_last;
   assign bit_cnt_o  = bcnt_q;

   always_comb begin
      ecnt_d = ecnt_q;
      bcnt_d = bcnt_q;
      s0_d   = at_s0 ? rx_i : s0_q;
      s1_d   = at_s1 ? rx_i : s1_q;
      maj_d  = at_s2 ? maj_now : maj_q;
      if (!run_i) begin
         // The detection cycle is edge 0 of the start bit.
         ecnt_d = start_i ? PRE_W'(1) : '0;
         bcnt_d = '0;
      end else if (at_last) begin
         ecnt_d = '0;
         bcnt_d = bcnt_q + BCNT_W'(1);
      end else begin
         ecnt_d = ecnt_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         ecnt_q <= '0;
         bcnt_q <= '0;
         s0_q   <= 1'b0;
         s1_q   <= 1'b0;
         maj_q  <= 1'b0;
      end else begin
         ecnt_q <= ecnt_d;
         bcnt_q <= bcnt_d;
         s0_q   <= s0_d;
         s1_q   <= s1_d;
         maj_q  <= maj_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, shift register, parity check, break
// detection and result/pulse registers around the bit sampler.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DW_MAX = 9,
   parameter int PRE_W  = 6
) (
   input  logic              clk,
   input  logic              ARST,
   input  logic              RX_IN,
   input  logic [PRE_W-1:0]  Prescale,
   input  logic [3:0]        DATA_LEN,
   input  logic              PAR_EN,
   input  logic              PAR_TYP,
   input  logic              STOP2,
   output logic [DW_MAX-1:0] P_DATA,
   output logic              data_valid,
   output logic              par_err,
   output logic              stp_err,
   output logic              strt_glitch,
   output logic              brk_det,
   output logic              rx_busy
);

   rx_state_e         state_q, state_d;
   logic [PRE_W-1:0]  pre_q, pre_d, pre_eff;
   logic [3:0]        len_q, len_d;
   logic              par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
   logic [DW_MAX-1:0] shreg_q, shreg_d, pdata_q, pdata_d;
   logic              par_acc_q, par_acc_d, par_bad_q, par_bad_d, par_bit_q, par_bit_d;
   logic              stp_bad_q, stp_bad_d, stop_sec_q, stop_sec_d;
   logic              dv_q, dv_d, pe_q, pe_d, se_q, se_d;
   logic              glitch_now, brk_now;
   logic              detect, run, samp_bit, bit_done;
   logic [BCNT_W-1:0] bit_cnt;

   assign detect  = (state_q == IDLE) && !RX_IN;
   assign run     = state_q inside {START, DATA, PARITY, STOP};
   assign pre_eff = (state_q == IDLE) ? Prescale : pre_q;

   uart_rx_sampler #(.PRE_W(PRE_W)) u_sampler (
      .clk        (clk),
      .rst_i      (ARST),
      .rx_i       (RX_IN),
      .run_i      (run),
      .start_i    (detect),
      .prescale_i (pre_eff),
      .bit_o      (samp_bit),
      .bit_done_o (bit_done),
      .bit_cnt_o  (bit_cnt)
   );

   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      len_d      = len_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      stop2_d    = stop2_q;
      shreg_d    = shreg_q;
      par_acc_d  = par_acc_q;
      par_bad_d  = par_bad_q;
      par_bit_d  = par_bit_q;
      stp_bad_d  = stp_bad_q;
      stop_sec_d = stop_sec_q;
      pdata_d    = pdata_q;
      dv_d       = 1'b0;
      pe_d       = 1'b0;
      se_d       = 1'b0;
      glitch_now = 1'b0;
      brk_now    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!RX_IN) begin
               state_d    = START;
               pre_d      = Prescale;
               len_d      = clamp_len(DATA_LEN, DW_MAX);
               par_en_d   = PAR_EN;
               par_typ_d  = PAR_TYP ? PAR_ODD : PAR_EVEN;
               stop2_d    = STOP2;
               shreg_d    = '0;
               par_acc_d  = 1'b0;
               par_bad_d  = 1'b0;
               par_bit_d  = 1'b0;
               stp_bad_d  = 1'b0;
               stop_sec_d = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               if (samp_bit) begin
                  glitch_now = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (bit_done) begin
               for (int i = 0; i < DW_MAX; i++)
                  if (bit_cnt == BCNT_W'(i + 1)) shreg_d[i] = samp_bit;
               par_acc_d = par_acc_q ^ samp_bit;
               if (bit_cnt == len_q) state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_done) begin
               par_bit_d = samp_bit;
               par_bad_d = samp_bit ^ par_acc_q ^ (par_typ_q == PAR_ODD);
               state_d   = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               // A line held low through the first stop bit is a break, not a framing error.
               if (!stop_sec_q && !samp_bit && (shreg_q == '0) && !(par_en_q && par_bit_q)) begin
                  brk_now = 1'b1;
                  state_d = BRK_WAIT;
               end else if (!stop_sec_q && stop2_q) begin
                  stop_sec_d = 1'b1;
                  stp_bad_d  = !samp_bit;
               end else begin
                  state_d = IDLE;
                  pe_d    = par_bad_q;
                  se_d    = stp_bad_q | !samp_bit;
                  dv_d    = !(par_bad_q | stp_bad_q | !samp_bit);
                  if (dv_d) pdata_d = shreg_q;
               end
            end
         end
         BRK_WAIT: begin
            if (RX_IN) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge ARST) begin
      if (ARST) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         len_q      <= 4'd5;
         par_en_q   <= 1'b0;
         par_typ_q  <= PAR_EVEN;
         stop2_q    <= 1'b0;
         shreg_q    <= '0;
         par_acc_q  <= 1'b0;
         par_bad_q  <= 1'b0;
         par_bit_q  <= 1'b0;
         stp_bad_q  <= 1'b0;
         stop_sec_q <= 1'b0;
         pdata_q    <= '0;
         dv_q       <= 1'b0;
         pe_q       <= 1'b0;
         se_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         len_q      <= len_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         stop2_q    <= stop2_d;
         shreg_q    <= shreg_d;
         par_acc_q  <= par_acc_d;
         par_bad_q  <= par_bad_d;
         par_bit_q  <= par_bit_d;
         stp_bad_q  <= stp_bad_d;
         stop_sec_q <= stop_sec_d;
         pdata_q    <= pdata_d;
         dv_q       <= dv_d;
         pe_q       <= pe_d;
         se_q       <= se_d;
      end
   end

   assign P_DATA      = pdata_q;
   assign data_valid  = dv_q;
   assign par_err     = pe_q;
   assign stp_err     = se_q;
   assign strt_glitch = glitch_now;
   assign brk_det     = brk_now;
   assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: per-cycle line waveforms with hand-computed
// pulse cycles and data values.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       ARST, RX_IN, PAR_EN, PAR_TYP, STOP2;
   logic [5:0] Prescale;
   logic [3:0] DATA_LEN;
   logic [8:0] P_DATA;
   logic       data_valid, par_err, stp_err, strt_glitch, brk_det, rx_busy;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DW_MAX(9), .PRE_W(6)) dut (
      .clk(clk), .ARST(ARST), .RX_IN(RX_IN), .Prescale(Prescale), .DATA_LEN(DATA_LEN),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(P_DATA),
      .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
      .strt_glitch(strt_glitch), .brk_det(brk_det), .rx_busy(rx_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic line_q[$];
   logic busy_log[$];
   int   dv_cnt, dv_first, dv_last, pe_cnt, pe_first, se_cnt, se_first;
   int   sg_cnt, sg_first, bd_cnt, bd_first;
   int   excl_cnt = 0;
   int   wide_cnt = 0;
   logic [8:0] pdata_first;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cfg(input logic [5:0] p, input logic [3:0] len, input logic pe, input logic pt, input logic s2);
      Prescale = p; DATA_LEN = len; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
   endtask

   task automatic add_idle(input int n, input logic lvl);
      repeat (n) line_q.push_back(lvl);
   endtask

   task automatic add_frame(input int p, input int nbits, input logic [8:0] data, input logic has_par,
                            input logic par_bit, input int nstop, input logic stop_a, input logic stop_b);
      logic lv[$];
      lv.push_back(1'b0);
      for (int i = 0; i < nbits; i++) lv.push_back(data[i]);
      if (has_par) lv.push_back(par_bit);
      lv.push_back(stop_a);
      if (nstop == 2) lv.push_back(stop_b);
      foreach (lv[i]) repeat (p) line_q.push_back(lv[i]);
   endtask

   // Cycle c: line level driven just after the rising edge, outputs sampled 1ns later.
   task automatic play(input int ncyc, input int chg_at, input logic [5:0] chg_val, input int rst_at, input int rst_len);
      logic [4:0] pulses, prev;
      dv_cnt = 0; pe_cnt = 0; se_cnt = 0; sg_cnt = 0; bd_cnt = 0;
      dv_first = -1; dv_last = -1; pe_first = -1; se_first = -1; sg_first = -1; bd_first = -1;
      pdata_first = '0;
      busy_log.delete();
      prev = '0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         RX_IN = (c < line_q.size()) ? line_q[c] : 1'b1;
         if (c == chg_at) Prescale = chg_val;
         if (rst_at >= 0) ARST = (c >= rst_at) && (c < rst_at + rst_len);
         #1;
         pulses = {data_valid, par_err, stp_err, strt_glitch, brk_det};
         busy_log.push_back(rx_busy);
         if (data_valid) begin
            if (dv_first < 0) begin dv_first = c; pdata_first = P_DATA; end
            dv_last = c; dv_cnt++;
         end
         if (par_err)     begin if (pe_first < 0) pe_first = c; pe_cnt++; end
         if (stp_err)     begin if (se_first < 0) se_first = c; se_cnt++; end
         if (strt_glitch) begin if (sg_first < 0) sg_first = c; sg_cnt++; end
         if (brk_det)     begin if (bd_first < 0) bd_first = c; bd_cnt++; end
         if (data_valid && (par_err || stp_err || strt_glitch || brk_det)) excl_cnt++;
         if ((pulses & prev) != 5'b0) wide_cnt++;
         prev = pulses;
      end
      line_q.delete();
   endtask

   initial begin
      ARST = 1'b1; RX_IN = 1'b1;
      cfg(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
      #12;
      check_eq("rst_pdata", 32'(P_DATA), 32'h0);
      check_eq("rst_busy", 32'(rx_busy), 32'h0);
      check_eq("rst_pulses", 32'({data_valid, par_err, stp_err, strt_glitch, brk_det}), 32'h0);
      @(posedge clk); #1 ARST = 1'b0;
      repeat (2) @(posedge clk);

      // 8N1, P=8, 0xA5
      add_frame(8, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      play(100, -1, 6'd0, -1, 0);
      check_eq("8n1_dv_cycle", 32'(dv_first), 32'd80);
      check_eq("8n1_dv_count", 32'(dv_cnt), 32'd1);
      check_eq("8n1_pdata", 32'(pdata_first), 32'h0A5);
      check_eq("8n1_errs", 32'(pe_cnt + se_cnt + sg_cnt + bd_cnt), 32'd0);
      check_eq("8n1_busy_79", 32'(busy_log[79]), 32'd1);
      check_eq("8n1_busy_80", 32'(busy_log[80]), 32'd0);

      // 8E1, P=16, 0x03 with wrong parity bit 1
      cfg(6'd16, 4'd8, 1'b1, 1'b0, 1'b0);
      add_frame(16, 8, 9'h003, 1'b1, 1'b1, 1, 1'b1, 1'b1);
      play(200, -1, 6'd0, -1, 0);
      check_eq("8e1_pe_cycle", 32'(pe_first), 32'd176);
      check_eq("8e1_pe_count", 32'(pe_cnt), 32'd1);
      check_eq("8e1_no_dv", 32'(dv_cnt + se_cnt), 32'd0);
      check_eq("8e1_pdata_hold", 32'(P_DATA), 32'h0A5);

      // Start glitch: 3 low cycles
      cfg(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
      add_idle(3, 1'b0);
      play(30, -1, 6'd0, -1, 0);
      check_eq("glitch_cycle", 32'(sg_first), 32'd7);
      check_eq("glitch_count", 32'(sg_cnt), 32'd1);
      check_eq("glitch_others", 32'(dv_cnt + pe_cnt + se_cnt + bd_cnt), 32'd0);
      check_eq("glitch_busy_8", 32'(busy_log[8]), 32'd0);

      // Break: line low for two 8N1 frames
      add_idle(160, 1'b0);
      play(200, -1, 6'd0, -1, 0);
      check_eq("brk_cycle", 32'(bd_first), 32'd79);
      check_eq("brk_count", 32'(bd_cnt), 32'd1);
      check_eq("brk_no_err", 32'(se_cnt + pe_cnt + dv_cnt + sg_cnt), 32'd0);
      check_eq("brk_wait_160", 32'(busy_log[160]), 32'd1);
      check_eq("brk_idle_161", 32'(busy_log[161]), 32'd0);

      // 5 data bits, 2 stop bits, P=4
      cfg(6'd4, 4'd5, 1'b0, 1'b0, 1'b1);
      add_frame(4, 5, 9'h015, 1'b0, 1'b0, 2, 1'b1, 1'b1);
      play(45, -1, 6'd0, -1, 0);
      check_eq("5n2_dv_cycle", 32'(dv_first), 32'd32);
      check_eq("5n2_pdata", 32'(pdata_first), 32'h015);
      add_frame(4, 5, 9'h00A, 1'b0, 1'b0, 2, 1'b1, 1'b0);
      play(45, -1, 6'd0, -1, 0);
      check_eq("5n2_se_cycle", 32'(se_first), 32'd32);
      check_eq("5n2_se_no_dv", 32'(dv_cnt + bd_cnt), 32'd0);
      check_eq("5n2_pdata_hold", 32'(P_DATA), 32'h015);

      // DATA_LEN=12 clamps to 9
      cfg(6'd4, 4'd12, 1'b0, 1'b0, 1'b0);
      add_frame(4, 9, 9'h1A5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      play(60, -1, 6'd0, -1, 0);
      check_eq("clamp9_dv_cycle", 32'(dv_first), 32'd44);
      check_eq("clamp9_pdata", 32'(pdata_first), 32'h1A5);

      // DATA_LEN=2 clamps to 5, odd parity, P=6, 0x13 (three ones -> parity bit 0)
      cfg(6'd6, 4'd2, 1'b1, 1'b1, 1'b0);
      add_frame(6, 5, 9'h013, 1'b1, 1'b0, 1, 1'b1, 1'b1);
      play(60, -1, 6'd0, -1, 0);
      check_eq("clamp5_dv_cycle", 32'(dv_first), 32'd48);
      check_eq("clamp5_pdata", 32'(pdata_first), 32'h013);
      check_eq("clamp5_no_pe", 32'(pe_cnt), 32'd0);

      // Parity and stop errors together: 8E1, 0x01, parity 0, stop 0
      cfg(6'd8, 4'd8, 1'b1, 1'b0, 1'b0);
      add_frame(8, 8, 9'h001, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      play(100, -1, 6'd0, -1, 0);
      check_eq("both_pe_cycle", 32'(pe_first), 32'd88);
      check_eq("both_se_cycle", 32'(se_first), 32'd88);
      check_eq("both_no_dv", 32'(dv_cnt + bd_cnt), 32'd0);

      // Reset during data bit 4
      cfg(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
      add_frame(8, 8, 9'h0FF, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      play(120, -1, 6'd0, 35, 3);
      check_eq("rstmid_busy_34", 32'(busy_log[34]), 32'd1);
      check_eq("rstmid_busy_36", 32'(busy_log[36]), 32'd0);
      check_eq("rstmid_pulses", 32'(dv_cnt + pe_cnt + se_cnt + sg_cnt + bd_cnt), 32'd0);
      check_eq("rstmid_pdata", 32'(P_DATA), 32'h0);

      // Frame starting in the first cycle after reset release
      add_idle(2, 1'b1);
      add_frame(8, 8, 9'h05A, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      play(110, -1, 6'd0, 0, 2);
      check_eq("postrst_dv_cycle", 32'(dv_first), 32'd82);
      check_eq("postrst_pdata", 32'(pdata_first), 32'h05A);

      // Prescale changed 8 -> 16 mid-frame
      add_frame(8, 8, 9'h0C6, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      play(100, 20, 6'd16, -1, 0);
      check_eq("prechg_dv_cycle", 32'(dv_first), 32'd80);
      check_eq("prechg_pdata", 32'(pdata_first), 32'h0C6);

      // Back-to-back frames with zero gap
      cfg(6'd8, 4'd8, 1'b0, 1'b0, 1'b0);
      add_frame(8, 8, 9'h03C, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      add_frame(8, 8, 9'h0C3, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      play(180, -1, 6'd0, -1, 0);
      check_eq("b2b_dv_count", 32'(dv_cnt), 32'd2);
      check_eq("b2b_dv_first", 32'(dv_first), 32'd80);
      check_eq("b2b_pdata_first", 32'(pdata_first), 32'h03C);
      check_eq("b2b_dv_last", 32'(dv_last), 32'd160);
      check_eq("b2b_pdata_last", 32'(P_DATA), 32'h0C3);

      check_eq("pulse_exclusive", 32'(excl_cnt), 32'd0);
      check_eq("pulse_width", 32'(wide_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
